// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the round-robin ROM read arbiter.
// The FSM encoding is fixed so state can be compared against known values.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;

    // Bits needed to index n items; valid for n >= 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set valid bit at or above ptr, wrapping modulo NUM_REQ.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module rr_priority_picker
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int PTR_WIDTH = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   valid,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [PTR_WIDTH-1:0] grant_idx,
    output logic                 any_valid
);

    logic                 found;
    logic [PTR_WIDTH-1:0] idx;

    assign any_valid = |valid;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_WIDTH'((int'(ptr) + i) % NUM_REQ);
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one combinational ROM port among NUM_REQ requesters, round-robin.
// Latency: accept at N, registered response at N+2. Backpressure: response holds until its owner is ready; no new accept meanwhile.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [ADDR_WIDTH-1:0]         rom_address,
    input  logic [DATA_WIDTH-1:0]         rom_data
);

    localparam int PW = clog2(NUM_REQ);

    state_t                  state;
    state_t                  state_nxt;
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           ptr_nxt;
    logic [PW-1:0]           owner;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [ADDR_WIDTH-1:0]   grant_addr;

    logic [NUM_REQ-1:0]      grant;
    logic [PW-1:0]           grant_idx;
    logic                    any_valid;
    logic                    rsp_done;
    logic                    accept;

    rr_priority_picker #(
        .NUM_REQ   (NUM_REQ),
        .PTR_WIDTH (PW)
    ) u_picker (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    assign rsp_done = (state == RESPOND) && rsp_ready[owner];
    assign ptr_nxt  = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_addr = grant_addr | req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = RESPOND;
            RESPOND: if (rsp_done) state_nxt = any_valid ? LOOKUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while reset is high so an aborted read never surfaces.
    always_comb begin
        accept    = 1'b0;
        req_ready = '0;
        rsp_valid = '0;
        if (!reset) begin
            case (state)
                IDLE:    accept = any_valid;
                RESPOND: begin
                    accept           = rsp_done && any_valid;
                    rsp_valid[owner] = 1'b1;
                end
                default: accept = 1'b0;
            endcase
            if (accept) begin
                req_ready = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr    <= '0;
            owner  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                owner  <= grant_idx;
                addr_q <= grant_addr;
                ptr    <= ptr_nxt;
            end
            if (state == LOOKUP) begin
                data_q <= rom_data;
            end
        end
    end

    assign rom_address = reset ? '0 : addr_q;
    assign rsp_data    = reset ? '0 : data_q;

endmodule
